// File: rtl/lcd_hd44780_rx.sv
// ---------------------------------------------------------------------------
// lcd_hd44780_rx
//
// HD44780-compatible write-side responder. It listens on the same 8-bit
// parallel bus (rs/rw/e/dat) that the LCD message writers drive, captures
// each write on the falling edge of e, decodes the instruction set and keeps
// a 2 x LINE_LEN character buffer plus the display/entry/function state.
// The buffer is readable through a registered read port so a writer can be
// checked on-chip or mirrored elsewhere. The block never drives the bus.
//
// Ports
//   clk, reset        system clock, synchronous active-low reset
//   lcd_rs/rw/e/dat   asynchronous bus inputs (synchronised internally)
//   rd_addr, rd_char  buffer read port, one cycle latency
//                     (0..LINE_LEN-1 = line 1, LINE_LEN..2*LINE_LEN-1 = line 2)
//   display_on, cursor_on, blink_on     display control bits D, C, B
//   entry_inc, entry_shift              entry mode bits I/D, S
//   mode_8bit, lines2, font5x10         function set bits DL, N, F
//   cursor_addr       current DDRAM address
//   busy              blank fill of the buffer in progress
//   cmd_valid         one-cycle pulse per accepted instruction
//   data_valid        one-cycle pulse per accepted data write
//   last_byte         byte of the most recent accepted event
//   overrun           sticky: an event arrived while busy
//   err_unsup         sticky: an unsupported operation was seen
//
// Only DATA_BITS = 8 is supported.
// ---------------------------------------------------------------------------
module lcd_hd44780_rx #(
    parameter int                    DATA_BITS  = 8,
    parameter int                    LINE_LEN   = 16,
    parameter logic [DATA_BITS-1:0]  BLANK_CHAR = 8'h20,
    localparam int                   IDX_W      = $clog2(2 * LINE_LEN)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 lcd_rs,
    input  logic                 lcd_rw,
    input  logic                 lcd_e,
    input  logic [DATA_BITS-1:0] lcd_dat,
    input  logic [IDX_W-1:0]     rd_addr,
    output logic [DATA_BITS-1:0] rd_char,
    output logic                 display_on,
    output logic                 cursor_on,
    output logic                 blink_on,
    output logic                 entry_inc,
    output logic                 entry_shift,
    output logic                 mode_8bit,
    output logic                 lines2,
    output logic                 font5x10,
    output logic [6:0]           cursor_addr,
    output logic                 busy,
    output logic                 cmd_valid,
    output logic                 data_valid,
    output logic [DATA_BITS-1:0] last_byte,
    output logic                 overrun,
    output logic                 err_unsup
);

    // DDRAM address map: line 1 at 0x00, line 2 at 0x40; each logical line
    // spans 40 addresses, of which the first LINE_LEN are buffered.
    localparam logic [6:0]       L1_LAST   = 7'h27;
    localparam logic [6:0]       L2_BASE   = 7'h40;
    localparam logic [6:0]       L2_LAST   = 7'h67;
    localparam logic [6:0]       LINE_END  = 7'(LINE_LEN);
    localparam logic [IDX_W-1:0] FILL_LAST = IDX_W'(2 * LINE_LEN - 1);
    localparam logic [IDX_W-1:0] L2_IDX    = IDX_W'(LINE_LEN);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    // Next DDRAM address after one step. Besides the two line wraps, the
    // unbuffered gaps 0x28-0x3F and 0x68-0x7F (reachable only by an explicit
    // set-address) roll over naturally: 0x3F+1 = 0x40, 0x7F+1 = 0x00.
    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) begin
            if (a == L1_LAST)      n = L2_BASE;
            else if (a == L2_LAST) n = 7'h00;
            else                   n = a + 7'd1;
        end else begin
            if (a == 7'h00)        n = L2_LAST;
            else if (a == L2_BASE) n = L1_LAST;
            else                   n = a - 7'd1;
        end
        return n;
    endfunction

    // ---- stage p0/p1: two-flop synchronisers, p2: previous synchronised e
    logic                 e_p0_q, e_p1_q, e_p2_q;
    logic                 rs_p0_q, rs_p1_q;
    logic                 rw_p0_q, rw_p1_q;
    logic [DATA_BITS-1:0] dat_p0_q, dat_p1_q;
    logic                 ev_vld_p2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_p0_q <= 1'b0;
            e_p1_q <= 1'b0;
            e_p2_q <= 1'b0;
        end else begin
            e_p0_q <= lcd_e;
            e_p1_q <= e_p0_q;
            e_p2_q <= e_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        rs_p0_q  <= lcd_rs;
        rs_p1_q  <= rs_p0_q;
        rw_p0_q  <= lcd_rw;
        rw_p1_q  <= rw_p0_q;
        dat_p0_q <= lcd_dat;
        dat_p1_q <= dat_p0_q;
    end

    // Falling edge of the synchronised strobe; rs/rw/dat are taken from
    // their synchronised copies in this same cycle.
    assign ev_vld_p2 = e_p2_q & ~e_p1_q;

    // ---- FSM: state register
    state_t           state_q, state_d;
    logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
    logic             busy_s;
    logic             fill_we;
    logic             clear_req;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_FILL;
            fill_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_idx_q <= fill_idx_d;
        end
    end

    // ---- FSM: next-state logic
    always_comb begin
        state_d    = state_q;
        fill_idx_d = fill_idx_q;
        case (state_q)
            ST_FILL: begin
                if (fill_idx_q == FILL_LAST) begin
                    state_d    = ST_IDLE;
                    fill_idx_d = '0;
                end else begin
                    fill_idx_d = fill_idx_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_d    = ST_FILL;
                    fill_idx_d = '0;
                end
            end
            default: begin
                state_d    = ST_FILL;
                fill_idx_d = '0;
            end
        endcase
    end

    // ---- FSM: outputs
    always_comb begin
        busy_s  = 1'b0;
        fill_we = 1'b0;
        if (state_q == ST_FILL) begin
            busy_s  = 1'b1;
            fill_we = 1'b1;
        end
    end

    // ---- stage p3: event decode into the registered display state
    logic                 disp_q, disp_d;
    logic                 curs_q, curs_d;
    logic                 blink_q, blink_d;
    logic                 inc_q, inc_d;
    logic                 shift_q, shift_d;
    logic                 dl_q, dl_d;
    logic                 n_q, n_d;
    logic                 f_q, f_d;
    logic [6:0]           cur_q, cur_d;
    logic                 cmd_vld_q, cmd_vld_d;
    logic                 data_vld_q, data_vld_d;
    logic [DATA_BITS-1:0] last_q, last_d;
    logic                 ovr_q, ovr_d;
    logic                 err_q, err_d;
    logic                 data_we;
    logic [IDX_W-1:0]     data_idx;

    always_comb begin
        disp_d     = disp_q;
        curs_d     = curs_q;
        blink_d    = blink_q;
        inc_d      = inc_q;
        shift_d    = shift_q;
        dl_d       = dl_q;
        n_d        = n_q;
        f_d        = f_q;
        cur_d      = cur_q;
        last_d     = last_q;
        ovr_d      = ovr_q;
        err_d      = err_q;
        cmd_vld_d  = 1'b0;
        data_vld_d = 1'b0;
        clear_req  = 1'b0;
        data_we    = 1'b0;
        data_idx   = '0;

        if (ev_vld_p2) begin
            if (busy_s) begin
                // Dropped entirely; only the sticky flag records it.
                ovr_d = 1'b1;
            end else if (rw_p1_q) begin
                // Reads are not serviced; the bus is never driven.
                err_d = 1'b1;
            end else if (rs_p1_q) begin
                data_vld_d = 1'b1;
                last_d     = dat_p1_q;
                if (cur_q < LINE_END) begin
                    data_we  = 1'b1;
                    data_idx = IDX_W'(cur_q);
                end else if ((cur_q >= L2_BASE) && (cur_q < (L2_BASE + LINE_END))) begin
                    data_we  = 1'b1;
                    data_idx = IDX_W'(cur_q - L2_BASE) + L2_IDX;
                end
                // Off-screen bytes are discarded but still move the cursor.
                cur_d = addr_step(cur_q, inc_q);
            end else begin
                cmd_vld_d = 1'b1;
                last_d    = dat_p1_q;
                casez (dat_p1_q)
                    8'b1???????: cur_d = dat_p1_q[6:0];
                    8'b01??????: err_d = 1'b1;
                    8'b001?????: begin
                        dl_d = dat_p1_q[4];
                        n_d  = dat_p1_q[3];
                        f_d  = dat_p1_q[2];
                        if (!dat_p1_q[4]) err_d = 1'b1;
                    end
                    8'b0001????: begin
                        // Display shift (SC=1) is not modelled.
                        if (dat_p1_q[3]) err_d = 1'b1;
                        else             cur_d = addr_step(cur_q, dat_p1_q[2]);
                    end
                    8'b00001???: begin
                        disp_d  = dat_p1_q[2];
                        curs_d  = dat_p1_q[1];
                        blink_d = dat_p1_q[0];
                    end
                    8'b000001??: begin
                        inc_d   = dat_p1_q[1];
                        shift_d = dat_p1_q[0];
                    end
                    8'b0000001?: cur_d = 7'h00;
                    8'b00000001: begin
                        cur_d     = 7'h00;
                        inc_d     = 1'b1;
                        clear_req = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            disp_q     <= 1'b0;
            curs_q     <= 1'b0;
            blink_q    <= 1'b0;
            inc_q      <= 1'b1;
            shift_q    <= 1'b0;
            dl_q       <= 1'b1;
            n_q        <= 1'b0;
            f_q        <= 1'b0;
            cur_q      <= 7'h00;
            cmd_vld_q  <= 1'b0;
            data_vld_q <= 1'b0;
            last_q     <= '0;
            ovr_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            disp_q     <= disp_d;
            curs_q     <= curs_d;
            blink_q    <= blink_d;
            inc_q      <= inc_d;
            shift_q    <= shift_d;
            dl_q       <= dl_d;
            n_q        <= n_d;
            f_q        <= f_d;
            cur_q      <= cur_d;
            cmd_vld_q  <= cmd_vld_d;
            data_vld_q <= data_vld_d;
            last_q     <= last_d;
            ovr_q      <= ovr_d;
            err_q      <= err_d;
        end
    end

    // ---- character buffer: one write port shared by fill and data writes
    // (mutually exclusive: fill only while busy, data only while idle).
    logic [DATA_BITS-1:0] buf_q [2*LINE_LEN];
    logic [DATA_BITS-1:0] rd_char_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            if (fill_we)      buf_q[fill_idx_q] <= BLANK_CHAR;
            else if (data_we) buf_q[data_idx]   <= dat_p1_q;
        end
    end

    // Registered read; a same-cycle write to the same index returns old data.
    always_ff @(posedge clk) begin
        if (!reset) rd_char_q <= '0;
        else        rd_char_q <= buf_q[rd_addr];
    end

    assign rd_char     = rd_char_q;
    assign display_on  = disp_q;
    assign cursor_on   = curs_q;
    assign blink_on    = blink_q;
    assign entry_inc   = inc_q;
    assign entry_shift = shift_q;
    assign mode_8bit   = dl_q;
    assign lines2      = n_q;
    assign font5x10    = f_q;
    assign cursor_addr = cur_q;
    assign busy        = busy_s;
    assign cmd_valid   = cmd_vld_q;
    assign data_valid  = data_vld_q;
    assign last_byte   = last_q;
    assign overrun     = ovr_q;
    assign err_unsup   = err_q;

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// ---------------------------------------------------------------------------
// tb_lcd_hd44780_rx
//
// Scoreboard bench for lcd_hd44780_rx. Each bus write is first applied to a
// behavioural LCD model (character array + cursor + flags); accepted events
// push the expected state snapshot into a queue, buffer reads push expected
// characters into a second queue, and an independent monitor pops and
// compares whenever the DUT pulses a valid or a read is pending.
// ---------------------------------------------------------------------------
module tb_lcd_hd44780_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_dat;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic       display_on, cursor_on, blink_on;
    logic       entry_inc, entry_shift;
    logic       mode_8bit, lines2, font5x10;
    logic [6:0] cursor_addr;
    logic       busy, cmd_valid, data_valid;
    logic [7:0] last_byte;
    logic       overrun, err_unsup;

    always #10 clk = ~clk;

    lcd_hd44780_rx dut (
        .clk         (clk),
        .reset       (reset),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_e       (lcd_e),
        .lcd_dat     (lcd_dat),
        .rd_addr     (rd_addr),
        .rd_char     (rd_char),
        .display_on  (display_on),
        .cursor_on   (cursor_on),
        .blink_on    (blink_on),
        .entry_inc   (entry_inc),
        .entry_shift (entry_shift),
        .mode_8bit   (mode_8bit),
        .lines2      (lines2),
        .font5x10    (font5x10),
        .cursor_addr (cursor_addr),
        .busy        (busy),
        .cmd_valid   (cmd_valid),
        .data_valid  (data_valid),
        .last_byte   (last_byte),
        .overrun     (overrun),
        .err_unsup   (err_unsup)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ model
    typedef struct packed {
        logic       is_data;
        logic [7:0] byte_v;
        logic [6:0] cur;
        logic [7:0] ctrl;
        logic       ovr;
        logic       err;
    } exp_t;

    exp_t       evq[$];
    logic [7:0] rdq[$];
    logic       rd_req;

    logic [7:0] m_buf [32];
    int         m_cur;
    logic       m_disp, m_curs, m_blink, m_inc, m_shift, m_dl, m_n, m_f;
    logic       m_ovr, m_err, m_busy;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
        m_cur = 0;
        m_disp = 0; m_curs = 0; m_blink = 0; m_inc = 1; m_shift = 0;
        m_dl = 1; m_n = 0; m_f = 0;
        m_ovr = 0; m_err = 0; m_busy = 0;
    endtask

    function automatic logic [7:0] m_ctrl();
        return {m_disp, m_curs, m_blink, m_inc, m_shift, m_dl, m_n, m_f};
    endfunction

    // Line 1 covers DDRAM 0..39, line 2 covers 64..103.
    function automatic int m_adv(input int a, input logic inc);
        if (inc) begin
            if (a == 39)  return 64;
            if (a == 103) return 0;
            return (a + 1) % 128;
        end
        if (a == 0)  return 103;
        if (a == 64) return 39;
        return a - 1;
    endfunction

    task automatic model_event(input logic rs, input logic rw, input logic [7:0] d);
        exp_t e;
        int   top;
        if (m_busy) begin m_ovr = 1; return; end
        if (rw)     begin m_err = 1; return; end
        if (rs) begin
            if (m_cur < 16)                     m_buf[m_cur] = d;
            else if (m_cur >= 64 && m_cur < 80) m_buf[m_cur - 64 + 16] = d;
            m_cur = m_adv(m_cur, m_inc);
        end else begin
            top = -1;
            for (int b = 7; b >= 0; b--) if (d[b] && top < 0) top = b;
            case (top)
                7: m_cur = int'(d[6:0]);
                6: m_err = 1;
                5: begin m_dl = d[4]; m_n = d[3]; m_f = d[2]; if (!d[4]) m_err = 1; end
                4: if (d[3]) m_err = 1; else m_cur = m_adv(m_cur, d[2]);
                3: begin m_disp = d[2]; m_curs = d[1]; m_blink = d[0]; end
                2: begin m_inc = d[1]; m_shift = d[0]; end
                1: m_cur = 0;
                0: begin
                    m_cur = 0; m_inc = 1; m_busy = 1;
                    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
                end
                default: ;
            endcase
        end
        e.is_data = rs;
        e.byte_v  = d;
        e.cur     = 7'(m_cur);
        e.ctrl    = m_ctrl();
        e.ovr     = m_ovr;
        e.err     = m_err;
        evq.push_back(e);
    endtask

    // ------------------------------------------------------------ monitor
    int   cyc = 0;
    int   rise_cyc = 0;
    bit   rise_vld = 0;
    logic busy_prev = 1'b1;
    int   n_cmd = 0, n_data = 0;

    always @(posedge clk) begin
        exp_t e;
        logic [7:0] r;
        #1;
        cyc++;
        if (!reset) begin
            rise_vld = 0;
        end else begin
            if (busy && !busy_prev) begin rise_cyc = cyc; rise_vld = 1; end
            if (!busy && busy_prev && rise_vld) begin
                check("clear_busy_len", 64'(cyc - rise_cyc), 64'd32);
                rise_vld = 0;
            end
            if (cmd_valid || data_valid) begin
                if (cmd_valid)  n_cmd++;
                if (data_valid) n_data++;
                if (evq.size() == 0) begin
                    check("spurious_valid", {cmd_valid, data_valid}, 2'b00);
                end else begin
                    e = evq.pop_front();
                    check("ev_kind_byte", {cmd_valid, data_valid, last_byte},
                          {~e.is_data, e.is_data, e.byte_v});
                    check("ev_state", {cursor_addr, display_on, cursor_on, blink_on, entry_inc,
                                       entry_shift, mode_8bit, lines2, font5x10, overrun, err_unsup},
                          {e.cur, e.ctrl, e.ovr, e.err});
                end
            end
            if (rd_req) begin
                if (rdq.size() == 0) begin
                    check("rd_queue_empty", 64'd1, 64'd0);
                end else begin
                    r = rdq.pop_front();
                    check($sformatf("rd_char[%0d]", rd_addr), rd_char, r);
                end
            end
        end
        busy_prev = busy;
    end

    // ------------------------------------------------------------ stimulus
    task automatic bus_write(input logic rs, input logic rw, input logic [7:0] d,
                             input int eh, input int el, input bit settle);
        model_event(rs, rw, d);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_dat = d; lcd_e = 1'b1;
        repeat (eh) @(negedge clk);
        lcd_e = 1'b0;
        repeat (el) @(negedge clk);
        if (settle && !rs && !rw && d == 8'h01) begin
            repeat (40) @(negedge clk);
            m_busy = 0;
        end
    endtask

    task automatic instr(input logic [7:0] d);
        bus_write(1'b0, 1'b0, d, 3, 6, 1'b1);
    endtask

    task automatic wr_data(input logic [7:0] d);
        bus_write(1'b1, 1'b0, d, 3, 6, 1'b1);
    endtask

    task automatic check_buf();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rd_addr = 5'(i);
            rd_req  = 1'b1;
            rdq.push_back(m_buf[i]);
        end
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic check_reset_vals(input bit exp_busy, input bit chk_rd);
        check("rst_ctrl", {display_on, cursor_on, blink_on, entry_inc, entry_shift,
                           mode_8bit, lines2, font5x10}, 8'b0001_0100);
        check("rst_cursor", cursor_addr, 7'h00);
        check("rst_valid", {cmd_valid, data_valid}, 2'b00);
        check("rst_last_byte", last_byte, 8'h00);
        check("rst_sticky", {overrun, err_unsup}, 2'b00);
        check("rst_busy", busy, exp_busy);
        if (chk_rd) check("rst_rd_char", rd_char, 8'h00);
    endtask

    task automatic release_reset();
        int n;
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy && n < 100);
        check("reset_busy_len", 64'(n), 64'd32);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string msg;
        int    c0, d0, r, eh, el;
        logic [7:0] b;
        logic [7:0] picks [16];

        msg = "ENTRA USUARIO Y*";
        reset = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_e = 1'b0; lcd_dat = 8'h00;
        rd_addr = 5'd0; rd_req = 1'b0;
        model_reset();

        // Reset state and initial blank fill.
        repeat (5) @(negedge clk);
        check_reset_vals(1'b1, 1'b1);
        release_reset();
        check_reset_vals(1'b0, 1'b0);
        check_buf();

        // Init sequence with long strobes (shortened from 1 ms).
        c0 = n_cmd;
        bus_write(1'b0, 1'b0, 8'h38, 2000, 6, 1'b1);
        bus_write(1'b0, 1'b0, 8'h06, 2000, 6, 1'b1);
        bus_write(1'b0, 1'b0, 8'h0C, 2000, 6, 1'b1);
        bus_write(1'b0, 1'b0, 8'h01, 2000, 6, 1'b1);
        check("init_flags", {lines2, mode_8bit, entry_inc, display_on, cursor_on}, 5'b11110);
        check("init_cmd_pulses", 64'(n_cmd - c0), 64'd4);

        // Sixteen characters on line 1.
        d0 = n_data;
        for (int i = 0; i < 16; i++) wr_data(msg[i]);
        check("msg_cursor", cursor_addr, 7'h10);
        check("msg_data_pulses", 64'(n_data - d0), 64'd16);
        check_buf();

        // Set address and wrap.
        instr(8'hC0);
        wr_data(8'h41);
        check("line2_cursor", cursor_addr, 7'h41);
        instr(8'hA7);
        check("setaddr_cursor", cursor_addr, 7'h27);
        wr_data(8'h5A);
        check("wrap_cursor", cursor_addr, 7'h40);
        check_buf();

        // Event while the clear fill runs is dropped.
        check("sticky_before", {overrun, err_unsup}, 2'b00);
        bus_write(1'b0, 1'b0, 8'h01, 2, 5, 1'b0);
        repeat (2) @(negedge clk);
        bus_write(1'b0, 1'b0, 8'h0F, 2, 5, 1'b0);
        check("overrun_set", overrun, 1'b1);
        repeat (40) @(negedge clk);
        m_busy = 0;
        check("dropped_no_change", display_on, 1'b1);

        // Read request is flagged, no pulse.
        c0 = n_cmd; d0 = n_data;
        bus_write(1'b0, 1'b1, 8'h5C, 3, 6, 1'b0);
        check("rw_err", err_unsup, 1'b1);
        check("rw_no_pulse", 64'((n_cmd - c0) + (n_data - d0)), 64'd0);

        // Display off keeps the buffer.
        for (int i = 0; i < 4; i++) wr_data(msg[i]);
        instr(8'h08);
        check("display_off", display_on, 1'b0);
        check_buf();

        // Reset in the middle of a clear fill restarts the fill.
        bus_write(1'b0, 1'b0, 8'h01, 2, 5, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals(1'b1, 1'b1);
        release_reset();
        check_reset_vals(1'b0, 1'b0);
        check_buf();

        // Randomised traffic against the model.
        picks = '{8'h00, 8'h0E, 8'h0F, 8'h10, 8'h26, 8'h27, 8'h28, 8'h3F,
                  8'h40, 8'h4E, 8'h4F, 8'h50, 8'h66, 8'h67, 8'h68, 8'h7F};
        for (int k = 0; k < 250; k++) begin
            r  = int'($urandom_range(0, 99));
            eh = int'($urandom_range(2, 5));
            el = int'($urandom_range(5, 7));
            if (r < 30 || r >= 80) begin
                bus_write(1'b1, 1'b0, 8'($urandom_range(32, 126)), eh, el, 1'b1);
            end else if (r < 40) begin
                b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 127))
                                                : picks[$urandom_range(0, 15)];
                bus_write(1'b0, 1'b0, 8'h80 | b, eh, el, 1'b1);
            end else if (r < 48) begin
                b = 8'h10 | 8'($urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) b = b | 8'h08;
                bus_write(1'b0, 1'b0, b, eh, el, 1'b1);
            end else if (r < 55) begin
                bus_write(1'b0, 1'b0, 8'h08 | 8'($urandom_range(0, 7)), eh, el, 1'b1);
            end else if (r < 62) begin
                bus_write(1'b0, 1'b0, 8'h04 | 8'($urandom_range(0, 3)), eh, el, 1'b1);
            end else if (r < 67) begin
                b = 8'h20 | 8'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0) b = b | 8'h10;
                bus_write(1'b0, 1'b0, b, eh, el, 1'b1);
            end else if (r < 70) begin
                bus_write(1'b0, 1'b0, 8'h02 | 8'($urandom_range(0, 1)), eh, el, 1'b1);
            end else if (r < 72) begin
                bus_write(1'b0, 1'b0, 8'h01, eh, el, 1'b1);
            end else if (r < 75) begin
                bus_write(1'b0, 1'b0, 8'h40 | 8'($urandom_range(0, 63)), eh, el, 1'b1);
            end else if (r < 77) begin
                bus_write(1'b0, 1'b0, 8'h00, eh, el, 1'b1);
            end else begin
                bus_write(1'($urandom_range(0, 1)), 1'b1, 8'($urandom), eh, el, 1'b1);
            end
            if (k % 50 == 49) check_buf();
        end

        repeat (10) @(negedge clk);
        check("events_outstanding", 64'(evq.size()), 64'd0);
        check("reads_outstanding", 64'(rdq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_rx.md
Name: lcd_hd44780_rx

Overview:
- Synthesizable HD44780-compatible responder. Sits on the same 8-bit parallel bus (rs/rw/e/data) that our LCD message writers drive.
- Captures each write on the falling edge of e, decodes the instruction set, and keeps a 2x16 character buffer plus display/entry state.
- Buffer contents are exposed on a read port, so the writer can be checked on-chip or mirrored to another output.

Parameters:
- DATA_BITS, 8, bus width; only 8 is supported.
- LINE_LEN, 16, characters per line; the buffer holds 2*LINE_LEN entries.
- BLANK_CHAR, 8'h20, fill value used on clear and reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low.
- lcd_rs  in  1  register select: 0 = instruction, 1 = data; asynchronous.
- lcd_rw  in  1  1 = read request; asynchronous.
- lcd_e  in  1  enable strobe; asynchronous.
- lcd_dat  in  8  bus data; asynchronous.
- rd_addr  in  5  buffer index; 0-15 = line 1, 16-31 = line 2.
- rd_char  out  8  buffer[rd_addr], registered.
- display_on, cursor_on, blink_on  out  1 each  display control bits (D, C, B).
- entry_inc, entry_shift  out  1 each  entry mode bits (I/D, S).
- mode_8bit, lines2, font5x10  out  1 each  function set bits (DL, N, F).
- cursor_addr  out  7  current DDRAM address.
- busy  out  1  clear fill in progress.
- cmd_valid, data_valid  out  1 each  one-cycle pulse per accepted instruction or data write.
- last_byte  out  8  byte captured by the most recent accepted event.
- overrun  out  1  sticky: an event arrived while busy.
- err_unsup  out  1  sticky: unsupported operation received.

Behaviour:
- Synchronisation: lcd_e, lcd_rs, lcd_rw and lcd_dat each pass through 2 flip-flops. A falling edge is detected when prev_e=1 and sync_e=0. rs/rw/dat are taken from their synchronized copies in that same cycle.
- Latency: count the first clk edge that samples lcd_e low as edge 1. The event is processed at edge 3; cmd_valid or data_valid is high for exactly the following cycle.
- FSM states: FILL and IDLE.
  - Reset: state=FILL, fill_idx=0.
  - FILL: writes BLANK_CHAR to buffer[fill_idx], one entry per cycle, for 32 cycles, busy=1. Then moves to IDLE with busy=0.
- Events while busy=1: dropped, no state change, no valid pulse, overrun<=1.
- rw=1 event: ignored, err_unsup<=1, no valid pulse. The block never drives the bus.
- Instructions (rs=0) decode on the highest set bit:
  - 1AAAAAAA (set DDRAM address): cursor_addr<=A.
  - 01xxxxxx (set CGRAM address): ignored, err_unsup<=1.
  - 001 DL N F xx (function set): mode_8bit, lines2, font5x10 load DL, N, F. DL=0 also sets err_unsup.
  - 0001 SC RL xx (cursor/display shift):
    - SC=0: cursor_addr steps right (RL=1) or left (RL=0) using the wrap rules below.
    - SC=1: err_unsup<=1, no other change.
  - 00001DCB (display control): loads display_on, cursor_on, blink_on. The buffer is untouched.
  - 000001 ID S (entry mode): loads entry_inc, entry_shift. S=1 is stored but does not move the buffer.
  - 0000001x (return home): cursor_addr<=0.
  - 00000001 (clear display): cursor_addr<=0, entry_inc<=1, go to FILL.
  - 00000000: no-op; cmd_valid still pulses.
- Data (rs=1):
  - Address 0x00-0x0F writes buffer index addr.
  - Address 0x40-0x4F writes buffer index addr-0x40+16.
  - Any other address: byte discarded, address still advances.
  - After the write, cursor_addr advances by entry_inc.
- Address advance and wrap:
  - Increment: 0x27->0x40, 0x67->0x00.
  - Decrement: 0x00->0x67, 0x40->0x27.
  - Addresses 0x28-0x3F and 0x68-0x7F only occur through set-address; advancing from them wraps 0x7F->0x00 and 0x3F->0x40.
- last_byte updates on every accepted event.
- Read port: rd_char <= buffer[rd_addr] one cycle after rd_addr is applied. A same-cycle write to the same index returns the old value. Reads during FILL are allowed.
- Reset values (asserted while reset=0, held through reset):
  - Control: display_on=0, cursor_on=0, blink_on=0, entry_inc=1, entry_shift=0, mode_8bit=1, lines2=0, font5x10=0.
  - Status: cursor_addr=0, busy=1, cmd_valid=0, data_valid=0, last_byte=0, overrun=0, err_unsup=0, rd_char=0.
- Reset mid-FILL: the fill restarts from index 0. overrun and err_unsup clear only on reset.
- An lcd_e glitch shorter than 1 clk may be missed; this is not an error.

Test Plan:
- Release reset -> busy=1 for exactly 32 cycles; every rd_addr 0-31 then returns 0x20; all other outputs at their reset values.
- Instructions 0x38, 0x06, 0x0C, 0x01, each e pulse 1 ms at a 50 MHz clock -> lines2=1, mode_8bit=1, entry_inc=1, display_on=1, cursor_on=0, 4 cmd_valid pulses; busy=1 for 32 cycles after the 0x01 event.
- 16 data writes "ENTRA USUARIO Y*" -> indices 0-15 read back those ASCII values, cursor_addr=0x10, 16 data_valid pulses.
- Set address and wrap:
  - 0xC0 then 'A' -> index 16=0x41, cursor_addr=0x41.
  - 0xA7 then 'Z' -> buffer unchanged, cursor_addr=0x40.
- Busy and unsupported:
  - An instruction issued 10 cycles after a 0x01 clear -> dropped, overrun=1.
  - An rw=1 pulse -> err_unsup=1, no valid pulse.
- 0x08 -> display_on=0, buffer intact. Assert reset at fill index 12 -> fill restarts at 0 and busy lasts 32 cycles after release.
